// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light codes and state encodings for the traffic controller and its sensor front end.
package traffic_pkg;
  localparam logic [1:0] RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2;
  typedef enum logic [1:0] {C_HWY_GREEN, C_HWY_YELLOW, C_SIDE_GREEN, C_SIDE_YELLOW} ctrl_state_t;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_QUAL = 3'd1, S_PRESENT = 3'd2, S_HOLD = 3'd3, S_FAULT = 3'd4
  } sensor_state_t;
endpackage

// File: rtl/road_sensor_conditioner_if.sv
// road_sensor_conditioner_if: raw detector input and conditioned request/status outputs.
interface road_sensor_conditioner_if #(parameter int CNT_W = 8);
  logic             sensor_raw;
  logic             x;
  logic             fault;
  logic [CNT_W-1:0] car_count;
  modport master (output sensor_raw, input x, fault, car_count);
  modport slave (input sensor_raw, output x, fault, car_count);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every DIV clocks, continuously high when DIV is 1.
module tick_prescaler #(parameter int DIV = 4) (
  input  logic clock,
  input  logic clear,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clock)
    if (clear) r_cnt <= '0;
    else r_cnt <= (r_cnt == W'(DIV - 1)) ? '0 : r_cnt + 1'b1;
  assign tick = r_cnt == W'(DIV - 1);
endmodule

// File: rtl/road_sensor_conditioner.sv
// road_sensor_conditioner: synchronises, debounces and hold-stretches the side-road loop into request x.
module road_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int DEBOUNCE  = 3,
  parameter int HOLD      = 4,
  parameter int STUCK_MAX = 64,
  parameter int CNT_W     = 8
) (
  input logic clock,
  input logic clear,
  road_sensor_conditioner_if.slave bus
);
  localparam int Q_W = $clog2(DEBOUNCE);
  localparam int H_W = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam int O_W = $clog2(STUCK_MAX);
  logic             r_s1, r_s2;
  logic             w_tick;
  sensor_state_t    r_state;
  logic [Q_W-1:0]   r_q_cnt;
  logic [H_W-1:0]   r_h_cnt;
  logic [O_W-1:0]   r_on_cnt;
  logic [CNT_W-1:0] r_count;
  logic             r_x, r_fault;
  tick_prescaler #(.DIV(TICK_DIV)) u_tick (.clock(clock), .clear(clear), .tick(w_tick));
  // x and fault are assigned alongside each state transition so they track the state register
  always_ff @(posedge clock) begin
    if (clear) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_state <= S_IDLE;
      r_q_cnt <= '0;
      r_h_cnt <= '0;
      r_on_cnt <= '0;
      r_count <= '0;
      r_x <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_s1 <= bus.sensor_raw;
      r_s2 <= r_s1;
      if (r_state > S_FAULT) begin
        r_state <= S_IDLE;
        r_x <= 1'b0;
        r_fault <= 1'b0;
      end else if (w_tick) begin
        case (r_state)
          S_IDLE:
            if (r_s2) begin
              r_state <= S_QUAL;
              r_q_cnt <= Q_W'(1);
            end
          S_QUAL:
            if (!r_s2) begin
              r_state <= S_IDLE;
              r_q_cnt <= '0;
            end else if (r_q_cnt == Q_W'(DEBOUNCE - 1)) begin
              r_state <= S_PRESENT;
              r_on_cnt <= '0;
              r_x <= 1'b1;
              r_count <= &r_count ? r_count : r_count + 1'b1;
            end else r_q_cnt <= r_q_cnt + 1'b1;
          S_PRESENT:
            if (!r_s2) begin
              r_state <= S_HOLD;
              r_h_cnt <= '0;
            end else if (r_on_cnt == O_W'(STUCK_MAX - 1)) begin
              r_state <= S_FAULT;
              r_x <= 1'b0;
              r_fault <= 1'b1;
            end else r_on_cnt <= r_on_cnt + 1'b1;
          S_HOLD:
            if (r_s2) begin
              r_state <= S_PRESENT;
              r_on_cnt <= '0;
            end else if (r_h_cnt == H_W'(HOLD - 1)) begin
              r_state <= S_IDLE;
              r_x <= 1'b0;
            end else r_h_cnt <= r_h_cnt + 1'b1;
          S_FAULT:
            if (!r_s2) begin
              r_state <= S_IDLE;
              r_fault <= 1'b0;
            end
          default: begin
            r_state <= S_IDLE;
            r_x <= 1'b0;
            r_fault <= 1'b0;
          end
        endcase
      end
    end
  end
  assign bus.x = r_x;
  assign bus.fault = r_fault;
  assign bus.car_count = r_count;
endmodule

// File: tb/tb_road_sensor_conditioner.sv
// tb_road_sensor_conditioner: directed checks of qualify, glitch reject, hold, stuck fault, saturation and prescaling.
module tb_road_sensor_conditioner;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int total = 0;
  int bad = 0;
  road_sensor_conditioner_if #(.CNT_W(8)) if0 ();
  road_sensor_conditioner_if #(.CNT_W(2)) if1 ();
  road_sensor_conditioner_if #(.CNT_W(8)) if2 ();
  road_sensor_conditioner #(.TICK_DIV(1), .DEBOUNCE(3), .HOLD(4), .STUCK_MAX(16), .CNT_W(8))
    u0 (.clock(clk), .clear(clear), .bus(if0.slave));
  road_sensor_conditioner #(.TICK_DIV(1), .DEBOUNCE(3), .HOLD(4), .STUCK_MAX(16), .CNT_W(2))
    u1 (.clock(clk), .clear(clear), .bus(if1.slave));
  road_sensor_conditioner #(.TICK_DIV(4), .DEBOUNCE(3), .HOLD(4), .STUCK_MAX(16), .CNT_W(8))
    u2 (.clock(clk), .clear(clear), .bus(if2.slave));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    if0.sensor_raw = 1'b0;
    if1.sensor_raw = 1'b0;
    if2.sensor_raw = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask
  task automatic test_reset;
    if0.sensor_raw = 1'b1;
    clear = 1'b1;
    step(3);
    clear = 1'b0;
    if0.sensor_raw = 1'b0;
    total++; if (if0.x !== 1'b0) begin bad++; $display("FAIL reset_x got %b want 0", if0.x); end
    total++; if (if0.fault !== 1'b0) begin bad++; $display("FAIL reset_fault got %b want 0", if0.fault); end
    total++; if (if0.car_count !== 8'd0) begin bad++; $display("FAIL reset_count got %0d want 0", if0.car_count); end
    total++; if (if2.x !== 1'b0) begin bad++; $display("FAIL reset_x_div4 got %b want 0", if2.x); end
  endtask
  task automatic test_qualify;
    do_reset();
    if0.sensor_raw = 1'b1;
    step(4);
    total++; if (if0.x !== 1'b0) begin bad++; $display("FAIL qual_edge4_x got %b want 0", if0.x); end
    step(1);
    total++; if (if0.x !== 1'b1) begin bad++; $display("FAIL qual_edge5_x got %b want 1", if0.x); end
    total++; if (if0.car_count !== 8'd1) begin bad++; $display("FAIL qual_count got %0d want 1", if0.car_count); end
    total++; if (if0.fault !== 1'b0) begin bad++; $display("FAIL qual_fault got %b want 0", if0.fault); end
    if0.sensor_raw = 1'b0;
    step(10);
  endtask
  task automatic test_glitch;
    logic saw;
    do_reset();
    saw = 1'b0;
    if0.sensor_raw = 1'b1;
    step(2);
    if0.sensor_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); saw |= if0.x; end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL glitch2_x got %b want 0", saw); end
    total++; if (if0.car_count !== 8'd0) begin bad++; $display("FAIL glitch2_count got %0d want 0", if0.car_count); end
    if0.sensor_raw = 1'b1;
    step(4);
    if0.sensor_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin step(1); saw |= if0.x; end
    total++; if (saw !== 1'b1) begin bad++; $display("FAIL pulse4_x got %b want 1", saw); end
    total++; if (if0.car_count !== 8'd1) begin bad++; $display("FAIL pulse4_count got %0d want 1", if0.car_count); end
    total++; if (if0.x !== 1'b0) begin bad++; $display("FAIL pulse4_end_x got %b want 0", if0.x); end
  endtask
  task automatic test_hold;
    logic saw_low;
    do_reset();
    if0.sensor_raw = 1'b1;
    step(5);
    if0.sensor_raw = 1'b0;
    step(6);
    total++; if (if0.x !== 1'b1) begin bad++; $display("FAIL hold_edge6_x got %b want 1", if0.x); end
    step(1);
    total++; if (if0.x !== 1'b0) begin bad++; $display("FAIL hold_edge7_x got %b want 0", if0.x); end
    if0.sensor_raw = 1'b1;
    step(5);
    total++; if (if0.car_count !== 8'd2) begin bad++; $display("FAIL hold_second_count got %0d want 2", if0.car_count); end
    saw_low = 1'b0;
    if0.sensor_raw = 1'b0;
    step(3);
    if0.sensor_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin step(1); saw_low |= ~if0.x; end
    total++; if (saw_low !== 1'b0) begin bad++; $display("FAIL rehigh_x_dropped got %b want 0", saw_low); end
    total++; if (if0.car_count !== 8'd2) begin bad++; $display("FAIL rehigh_count got %0d want 2", if0.car_count); end
    if0.sensor_raw = 1'b0;
    step(10);
  endtask
  task automatic test_stuck;
    do_reset();
    if0.sensor_raw = 1'b1;
    step(5);
    total++; if (if0.x !== 1'b1) begin bad++; $display("FAIL stuck_edge5_x got %b want 1", if0.x); end
    step(15);
    total++; if (if0.fault !== 1'b0) begin bad++; $display("FAIL stuck_edge20_fault got %b want 0", if0.fault); end
    step(1);
    total++; if (if0.fault !== 1'b1) begin bad++; $display("FAIL stuck_edge21_fault got %b want 1", if0.fault); end
    total++; if (if0.x !== 1'b0) begin bad++; $display("FAIL stuck_edge21_x got %b want 0", if0.x); end
    if0.sensor_raw = 1'b0;
    step(2);
    total++; if (if0.fault !== 1'b1) begin bad++; $display("FAIL unstick_edge2_fault got %b want 1", if0.fault); end
    step(1);
    total++; if (if0.fault !== 1'b0) begin bad++; $display("FAIL unstick_edge3_fault got %b want 0", if0.fault); end
    total++; if (if0.car_count !== 8'd1) begin bad++; $display("FAIL stuck_count got %0d want 1", if0.car_count); end
  endtask
  task automatic test_saturate;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if1.sensor_raw = 1'b1;
      step(6);
      if1.sensor_raw = 1'b0;
      step(10);
      if (i == 1) begin
        total++; if (if1.car_count !== 2'd2) begin bad++; $display("FAIL sat_two_cars got %0d want 2", if1.car_count); end
      end
    end
    total++; if (if1.car_count !== 2'd3) begin bad++; $display("FAIL sat_five_cars got %0d want 3", if1.car_count); end
    total++; if (if1.x !== 1'b0) begin bad++; $display("FAIL sat_end_x got %b want 0", if1.x); end
  endtask
  task automatic test_prescale;
    do_reset();
    if2.sensor_raw = 1'b1;
    step(11);
    total++; if (if2.x !== 1'b0) begin bad++; $display("FAIL div4_edge11_x got %b want 0", if2.x); end
    step(1);
    total++; if (if2.x !== 1'b1) begin bad++; $display("FAIL div4_edge12_x got %b want 1", if2.x); end
    total++; if (if2.car_count !== 8'd1) begin bad++; $display("FAIL div4_count got %0d want 1", if2.car_count); end
    if2.sensor_raw = 1'b0;
    step(4);
    total++; if (if2.x !== 1'b1) begin bad++; $display("FAIL div4_hold_x got %b want 1", if2.x); end
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    total++; if (if2.x !== 1'b0) begin bad++; $display("FAIL clear_hold_x got %b want 0", if2.x); end
    total++; if (if2.car_count !== 8'd0) begin bad++; $display("FAIL clear_hold_count got %0d want 0", if2.car_count); end
    total++; if (if2.fault !== 1'b0) begin bad++; $display("FAIL clear_hold_fault got %b want 0", if2.fault); end
    if2.sensor_raw = 1'b1;
    step(11);
    total++; if (if2.x !== 1'b0) begin bad++; $display("FAIL reidle_edge11_x got %b want 0", if2.x); end
    step(1);
    total++; if (if2.x !== 1'b1) begin bad++; $display("FAIL reidle_edge12_x got %b want 1", if2.x); end
  endtask
  initial begin
    if0.sensor_raw = 1'b0;
    if1.sensor_raw = 1'b0;
    if2.sensor_raw = 1'b0;
    step(1);
    test_reset();
    test_qualify();
    test_glitch();
    test_hold();
    test_stuck();
    test_saturate();
    test_prescale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
